iob_ram_tdp_be_pipe: RTL and testbench

IOB_RAM_TDP_BE_PIPE -- requirements
Module: iob_ram_tdp_be_pipe

---
 rtl/iob_ram_tdp_be_pipe.sv | 223 ++++++++++++++++++++++
 tb/tb_iob_ram_tdp_be_pipe.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/iob_ram_tdp_be_pipe.sv
// True dual-port RAM with byte-lane write enables, an optional output
// pipeline stage per port, selectable same-port read-during-write
// behaviour and a saturating write-write collision counter.
// Port A has priority on overlapping lanes when both ports write one word.
module iob_ram_tdp_be_pipe #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter int OUT_REG  = 0,
  parameter int RDW_MODE = 0,
  parameter int CNT_W    = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  enA_i,
  input  logic                  enB_i,
  input  logic [DATA_W/8-1:0]   weA_i,
  input  logic [DATA_W/8-1:0]   weB_i,
  input  logic [ADDR_W-1:0]     addrA_i,
  input  logic [ADDR_W-1:0]     addrB_i,
  input  logic [DATA_W-1:0]     dA_i,
  input  logic [DATA_W-1:0]     dB_i,
  output logic [DATA_W-1:0]     dA_o,
  output logic [DATA_W-1:0]     dB_o,
  output logic                  dA_valid_o,
  output logic                  dB_valid_o,
  output logic                  collision_o,
  output logic [CNT_W-1:0]      collision_cnt_o
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  // Replace the lanes selected by mask with the corresponding lanes of new_w.
  function automatic logic [DATA_W-1:0] merge_lanes(
    input logic [DATA_W-1:0] old_w,
    input logic [DATA_W-1:0] new_w,
    input logic [NB-1:0]     mask
  );
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int k = 0; k < NB; k++) begin
      if (mask[k]) begin
        res[8*k +: 8] = new_w[8*k +: 8];
      end else begin
        res[8*k +: 8] = old_w[8*k +: 8];
      end
    end
    return res;
  endfunction

  // Storage is deliberately not reset: reset must leave contents intact.
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              same_addr_s;
  logic [NB-1:0]     we_a_eff_s;
  logic [NB-1:0]     we_b_eff_s;
  logic [DATA_W-1:0] old_a_s;
  logic [DATA_W-1:0] old_b_s;
  logic [DATA_W-1:0] rd_a_s;
  logic [DATA_W-1:0] rd_b_s;

  logic [DATA_W-1:0] a_data_q, a_data_d;
  logic [DATA_W-1:0] b_data_q, b_data_d;
  logic              a_vld_q,  a_vld_d;
  logic              b_vld_q,  b_vld_d;
  logic              coll_q,   coll_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;

  assign same_addr_s = (addrA_i == addrB_i);
  assign old_a_s     = mem_q[addrA_i];
  assign old_b_s     = mem_q[addrB_i];

  // Effective lane enables: nothing is written in reset, and B yields
  // overlapping lanes to A when both target the same word.
  always_comb begin
    we_a_eff_s = '0;
    we_b_eff_s = '0;
    if (rst_n_i && enA_i) begin
      we_a_eff_s = weA_i;
    end else begin
      we_a_eff_s = '0;
    end
    if (rst_n_i && enB_i) begin
      if (enA_i && same_addr_s) begin
        we_b_eff_s = weB_i & ~weA_i;
      end else begin
        we_b_eff_s = weB_i;
      end
    end else begin
      we_b_eff_s = '0;
    end
  end

  // Byte-lane memory write; A and B lanes never overlap on the same word.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < NB; k++) begin
      if (we_a_eff_s[k]) begin
        mem_q[addrA_i][8*k +: 8] <= dA_i[8*k +: 8];
      end
      if (we_b_eff_s[k]) begin
        mem_q[addrB_i][8*k +: 8] <= dB_i[8*k +: 8];
      end
    end
  end

  // Read word: pre-write contents, or own write merged in for write-first.
  always_comb begin
    rd_a_s = old_a_s;
    rd_b_s = old_b_s;
    if (RDW_MODE != 0) begin
      rd_a_s = merge_lanes(old_a_s, dA_i, we_a_eff_s);
      rd_b_s = merge_lanes(old_b_s, dB_i, we_b_eff_s);
    end else begin
      rd_a_s = old_a_s;
      rd_b_s = old_b_s;
    end
  end

  // First read stage and collision detection next-state.
  always_comb begin
    a_data_d = a_data_q;
    b_data_d = b_data_q;
    a_vld_d  = 1'b0;
    b_vld_d  = 1'b0;
    coll_d   = 1'b0;
    cnt_d    = cnt_q;
    if (enA_i) begin
      a_data_d = rd_a_s;
      a_vld_d  = 1'b1;
    end else begin
      a_data_d = a_data_q;
      a_vld_d  = 1'b0;
    end
    if (enB_i) begin
      b_data_d = rd_b_s;
      b_vld_d  = 1'b1;
    end else begin
      b_data_d = b_data_q;
      b_vld_d  = 1'b0;
    end
    coll_d = enA_i && enB_i && same_addr_s && (|(weA_i & weB_i));
    if (coll_d && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // First read stage and collision registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      a_data_q <= '0;
      b_data_q <= '0;
      a_vld_q  <= 1'b0;
      b_vld_q  <= 1'b0;
      coll_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      a_data_q <= a_data_d;
      b_data_q <= b_data_d;
      a_vld_q  <= a_vld_d;
      b_vld_q  <= b_vld_d;
      coll_q   <= coll_d;
      cnt_q    <= cnt_d;
    end
  end

  assign collision_o     = coll_q;
  assign collision_cnt_o = cnt_q;

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_W-1:0] a_data2_q, a_data2_d;
      logic [DATA_W-1:0] b_data2_q, b_data2_d;
      logic              a_vld2_q,  a_vld2_d;
      logic              b_vld2_q,  b_vld2_d;

      // Second stage captures only real results so idle ports hold data.
      always_comb begin
        a_data2_d = a_data2_q;
        b_data2_d = b_data2_q;
        a_vld2_d  = a_vld_q;
        b_vld2_d  = b_vld_q;
        if (a_vld_q) begin
          a_data2_d = a_data_q;
        end else begin
          a_data2_d = a_data2_q;
        end
        if (b_vld_q) begin
          b_data2_d = b_data_q;
        end else begin
          b_data2_d = b_data2_q;
        end
      end

      // Output pipeline registers; reset discards anything in flight.
      always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
          a_data2_q <= '0;
          b_data2_q <= '0;
          a_vld2_q  <= 1'b0;
          b_vld2_q  <= 1'b0;
        end else begin
          a_data2_q <= a_data2_d;
          b_data2_q <= b_data2_d;
          a_vld2_q  <= a_vld2_d;
          b_vld2_q  <= b_vld2_d;
        end
      end

      assign dA_o       = a_data2_q;
      assign dB_o       = b_data2_q;
      assign dA_valid_o = a_vld2_q;
      assign dB_valid_o = b_vld2_q;
    end else begin : g_no_out_reg
      assign dA_o       = a_data_q;
      assign dB_o       = b_data_q;
      assign dA_valid_o = a_vld_q;
      assign dB_valid_o = b_vld_q;
    end
  endgenerate

endmodule

// File: tb/tb_iob_ram_tdp_be_pipe.sv
// Scoreboard bench: two RAM instances (latency 1 / read-first / 16-bit
// counter, and latency 2 / write-first / 2-bit counter) share one stimulus
// stream; a word-level reference model predicts every response.
module tb_iob_ram_tdp_be_pipe;

  typedef struct {
    logic [31:0] data;
    bit          known;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enA, enB;
  logic [3:0]  weA, weB, addrA, addrB;
  logic [31:0] dA, dB;

  logic [31:0] a0_o, b0_o, a1_o, b1_o;
  logic        a0_v, b0_v, a1_v, b1_v, col0, col1;
  logic [15:0] cnt0;
  logic [1:0]  cnt1;

  int  chk = 0;
  int  err = 0;
  int  edge_cnt = 0;
  logic rst_smp = 1'b0;

  int  lat  [2] = '{1, 2};
  int  rdw  [2] = '{0, 1};
  int  cmax [2] = '{65535, 3};

  logic [31:0] mem_m [16];
  bit          known [16];
  exp_t        sq [2][2][$];
  int          cq [2][$];
  logic [31:0] last_d [2][2];
  bit          last_k [2][2];
  int          exp_cnt [2];

  always #5 clk = ~clk;

  iob_ram_tdp_be_pipe #(.DATA_W(32), .ADDR_W(4), .OUT_REG(0), .RDW_MODE(0), .CNT_W(16)) dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .enA_i(enA), .enB_i(enB), .weA_i(weA), .weB_i(weB),
    .addrA_i(addrA), .addrB_i(addrB), .dA_i(dA), .dB_i(dB), .dA_o(a0_o), .dB_o(b0_o),
    .dA_valid_o(a0_v), .dB_valid_o(b0_v), .collision_o(col0), .collision_cnt_o(cnt0));

  iob_ram_tdp_be_pipe #(.DATA_W(32), .ADDR_W(4), .OUT_REG(1), .RDW_MODE(1), .CNT_W(2)) dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .enA_i(enA), .enB_i(enB), .weA_i(weA), .weB_i(weB),
    .addrA_i(addrA), .addrB_i(addrB), .dA_i(dA), .dB_i(dB), .dA_o(a1_o), .dB_o(b1_o),
    .dA_valid_o(a1_v), .dB_valid_o(b1_v), .collision_o(col1), .collision_cnt_o(cnt1));

  // Edge counter and the reset value each edge saw.
  always @(posedge clk) begin
    edge_cnt <= edge_cnt + 1;
    rst_smp  <= rst_n;
  end

  function automatic logic [31:0] apply_lanes(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] m);
    logic [31:0] r;
    r = old_w;
    for (int k = 0; k < 4; k++) if (m[k]) r[8*k +: 8] = new_w[8*k +: 8];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    chk++;
    if (act !== expv) begin
      err++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, expv, $time);
    end
  endtask

  // One cycle of stimulus; the model predicts responses and updates memory.
  task automatic drive(input logic rn, input logic ea, input logic [3:0] wa, input logic [3:0] aa,
                       input logic [31:0] da, input logic eb, input logic [3:0] wb,
                       input logic [3:0] ab, input logic [31:0] db);
    logic [31:0] old_a, old_b;
    logic [3:0]  wb_own;
    rst_n = rn; enA = ea; weA = wa; addrA = aa; dA = da;
    enB = eb; weB = wb; addrB = ab; dB = db;
    if (!rn) begin
      for (int d = 0; d < 2; d++) begin
        for (int p = 0; p < 2; p++)
          while (sq[d][p].size() > 0 && sq[d][p][$].due > edge_cnt) void'(sq[d][p].pop_back());
        while (cq[d].size() > 0 && cq[d][$] > edge_cnt) void'(cq[d].pop_back());
      end
    end else begin
      old_a  = mem_m[aa];
      old_b  = mem_m[ab];
      wb_own = (ea && aa == ab) ? (wb & ~wa) : wb;
      for (int d = 0; d < 2; d++) begin
        if (ea) sq[d][0].push_back('{rdw[d] != 0 ? apply_lanes(old_a, da, wa) : old_a,
                                     known[aa] || (rdw[d] != 0 && wa == 4'hF), edge_cnt + lat[d]});
        if (eb) sq[d][1].push_back('{rdw[d] != 0 ? apply_lanes(old_b, db, wb_own) : old_b,
                                     known[ab] || (rdw[d] != 0 && wb_own == 4'hF), edge_cnt + lat[d]});
        if (ea && eb && aa == ab && (wa & wb) != 4'h0) cq[d].push_back(edge_cnt + 1);
      end
      // B first, then A on top: A owns any lane both ports wrote.
      if (eb) begin
        mem_m[ab] = apply_lanes(mem_m[ab], db, wb);
        if (wb == 4'hF) known[ab] = 1'b1;
      end
      if (ea) begin
        mem_m[aa] = apply_lanes(mem_m[aa], da, wa);
        if (wa == 4'hF) known[aa] = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic mon_port(input int d, input int p, input logic [31:0] data, input logic v);
    exp_t e;
    string nm;
    nm = $sformatf("dut%0d_%s", d, p == 0 ? "A" : "B");
    if (v) begin
      chk++;
      if (sq[d][p].size() == 0) begin
        err++;
        $display("FAIL %s_unexpected_valid actual=1 expected=0 t=%0t", nm, $time);
      end else begin
        e = sq[d][p].pop_front();
        check({nm, "_latency"}, edge_cnt, e.due);
        if (e.known) check({nm, "_data"}, data, e.data);
        last_d[d][p] = e.data;
        last_k[d][p] = e.known;
      end
    end else begin
      if (sq[d][p].size() > 0 && sq[d][p][0].due <= edge_cnt) begin
        chk++; err++;
        $display("FAIL %s_missing_valid actual=0 expected=1 t=%0t", nm, $time);
        void'(sq[d][p].pop_front());
      end
      if (last_k[d][p]) check({nm, "_hold"}, data, last_d[d][p]);
    end
  endtask

  task automatic mon(input int d, input logic [31:0] ao, input logic av, input logic [31:0] bo,
                     input logic bv, input logic col, input logic [15:0] cnt);
    bit ec;
    if (!rst_smp) begin
      check($sformatf("dut%0d_reset_outputs", d), {ao | bo, 16'h0, cnt} | {28'h0, av, bv, col, 1'b0},
            32'h0);
      exp_cnt[d] = 0;
      for (int p = 0; p < 2; p++) begin
        last_d[d][p] = 32'h0;
        last_k[d][p] = 1'b1;
      end
    end else begin
      mon_port(d, 0, ao, av);
      mon_port(d, 1, bo, bv);
      ec = (cq[d].size() > 0 && cq[d][0] == edge_cnt);
      if (ec) begin
        void'(cq[d].pop_front());
        if (exp_cnt[d] < cmax[d]) exp_cnt[d]++;
      end
      check($sformatf("dut%0d_collision", d), {31'h0, col}, {31'h0, ec});
      check($sformatf("dut%0d_coll_cnt", d), {16'h0, cnt}, exp_cnt[d]);
    end
  endtask

  // Monitor: compares both instances away from the active edge.
  always @(negedge clk) begin
    mon(0, a0_o, a0_v, b0_o, b0_v, col0, cnt0);
    mon(1, a1_o, a1_v, b1_o, b1_v, col1, {14'h0, cnt1});
  end

  logic [3:0] ra;

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem_m[i] = 32'h0;
      known[i] = 1'b0;
    end
    rst_n = 1'b0; enA = 1'b0; enB = 1'b0; weA = 4'h0; weB = 4'h0;
    addrA = 4'h0; addrB = 4'h0; dA = 32'h0; dB = 32'h0;
    @(posedge clk);
    #1;
    // Writes offered during reset must be ignored.
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 4'hF, 4'(i), 32'hBAD0_0000, 1'b0, 4'h0, 4'h0, 32'h0);
    // Port A fill then read back.
    for (int i = 0; i < 16; i++) drive(1'b1, 1'b1, 4'hF, 4'(i), 32'(32 + i), 1'b0, 4'h0, 4'h0, 32'h0);
    for (int i = 0; i < 16; i++) drive(1'b1, 1'b1, 4'h0, 4'(i), 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
    // Port B fill, port A reads, then a single-lane write by B.
    for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'hF, 4'(i), 32'(64 + i));
    for (int i = 0; i < 16; i++) drive(1'b1, 1'b1, 4'h0, 4'(i), 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
    drive(1'b1, 1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'b0010, 4'd3, 32'hAABBCCDD);
    drive(1'b1, 1'b1, 4'h0, 4'd3, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
    // Full-lane collision, then disjoint-lane merge on the same word.
    drive(1'b1, 1'b1, 4'hF, 4'd5, 32'h11111111, 1'b1, 4'hF, 4'd5, 32'h22222222);
    drive(1'b1, 1'b1, 4'h0, 4'd5, 32'h0, 1'b1, 4'h0, 4'd5, 32'h0);
    drive(1'b1, 1'b1, 4'h3, 4'd5, 32'h11111111, 1'b1, 4'hC, 4'd5, 32'h22222222);
    drive(1'b1, 1'b1, 4'h0, 4'd5, 32'h0, 1'b1, 4'h0, 4'd5, 32'h0);
    // Read-during-write on addr 7, same port and cross port.
    drive(1'b1, 1'b1, 4'hF, 4'd7, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
    drive(1'b1, 1'b1, 4'hF, 4'd7, 32'hDEADBEEF, 1'b1, 4'h0, 4'd7, 32'h0);
    drive(1'b1, 1'b1, 4'h0, 4'd7, 32'h0, 1'b1, 4'h0, 4'd7, 32'h0);
    // Reads streaming when a one-cycle reset hits; a write inside reset is dropped.
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b1, 4'h0, 4'(i), 32'h0, 1'b1, 4'h0, 4'(15 - i), 32'h0);
    drive(1'b0, 1'b1, 4'hF, 4'd2, 32'hCAFEF00D, 1'b1, 4'h0, 4'd4, 32'h0);
    for (int i = 0; i < 16; i++) drive(1'b1, 1'b1, 4'h0, 4'(i), 32'h0, 1'b1, 4'h0, 4'(i), 32'h0);
    // Five collisions: the 2-bit counter must stop at 3.
    for (int i = 0; i < 5; i++)
      drive(1'b1, 1'b1, 4'(1 << (i % 4)), 4'd9, $urandom, 1'b1, 4'hF, 4'd9, $urandom);
    drive(1'b1, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
    drive(1'b1, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
    // Randomised traffic with frequent address clashes and rare resets.
    for (int n = 0; n < 400; n++) begin
      ra = 4'($urandom_range(15));
      drive(($urandom_range(99) != 0), ($urandom_range(9) < 7), 4'($urandom), ra, $urandom,
            ($urandom_range(9) < 7), 4'($urandom), ($urandom_range(2) == 0) ? ra : 4'($urandom_range(15)),
            $urandom);
    end
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 4'hF, 4'h0, 32'h0, 1'b0, 4'hF, 4'h0, 32'h0);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("dut%0d_A_drained", d), sq[d][0].size(), 32'h0);
      check($sformatf("dut%0d_B_drained", d), sq[d][1].size(), 32'h0);
      check($sformatf("dut%0d_coll_drained", d), cq[d].size(), 32'h0);
    end
    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end

endmodule
